// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// EX-stage branch/jump resolution codes and the hard-wired zero register.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MULDIV   = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] BJ_NONE = 2'b00;
    localparam logic [1:0] BJ_BR   = 2'b01;
    localparam logic [1:0] BJ_J    = 2'b10;
    localparam logic [1:0] BJ_JR   = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Any non-zero resolution code means EX is redirecting the fetch stream.
    function automatic logic is_redirect(input logic [1:0] bj);
        return bj != BJ_NONE;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: a load in ID/EX whose destination is
// read by the instruction sitting in IF/ID.
import pipe_ctrl_pkg::*;

module load_use_detect (
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    output logic       load_use
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (idex_rt == ifid_rs);
        rt_match = ifid_uses_rt && (idex_rt == ifid_rt);
        // Writes to $zero are discarded, so they never create a dependency.
        load_use = idex_mem_read && (idex_rt != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Prioritised stall/flush sequencer for the 5-stage pipeline: memory hold,
// EX redirect, mul/div occupancy and load-use, plus a redirect counter.
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int          MULDIV_LAT = 32,
    parameter int          CNT_W      = 6,
    parameter logic [15:0] RC_MAX     = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  branch_jump,
    input  logic        muldiv_start,
    input  logic        mem_busy,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pipe_hold,
    output logic        muldiv_busy,
    output logic [15:0] redirect_count,
    output logic [1:0]  state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    ctrl_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             load_use;

    load_use_detect u_load_use_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .ifid_uses_rt  (ifid_uses_rt),
        .load_use      (load_use)
    );

    // State, mul/div countdown and redirect counter all freeze on mem_busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            cnt            <= '0;
            redirect_count <= '0;
        end else if (!mem_busy) begin
            case (state)
                RUN: begin
                    if (is_redirect(branch_jump)) begin
                        state <= REDIRECT;
                        if (redirect_count != RC_MAX) begin
                            redirect_count <= redirect_count + 16'd1;
                        end
                    end else if (muldiv_start) begin
                        state <= MULDIV;
                        cnt   <= CNT_LOAD;
                    end
                end
                REDIRECT: begin
                    state <= RUN;
                end
                MULDIV: begin
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output decode; reset forces the defaults regardless of the inputs.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_hold   = 1'b0;
        muldiv_busy = 1'b0;
        if (rst_n) begin
            muldiv_busy = (state == MULDIV);
            if (mem_busy) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (is_redirect(branch_jump)) begin
                            ifid_flush = 1'b1;
                            idex_flush = 1'b1;
                        end else if (!muldiv_start && load_use) begin
                            pc_write   = 1'b0;
                            ifid_write = 1'b0;
                            idex_flush = 1'b1;
                        end
                    end
                    MULDIV: begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule
